// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key-schedule controller: one expansion round per cycle, 11 stored round keys, random-access read.
// Optional zeroize input and post-run working-register wipe enabled by macro KEY_SCHED_ZEROIZE_EN.

module aes128_key_exp_round (
  input  logic [127:0] i_w,
  input  logic [31:0]  i_rcon,
  output logic [127:0] o_w
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    p = gf_mul(a, a);
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w_rot;
  logic [31:0] w_t;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  assign w_rot = {i_w[23:0], i_w[31:24]};
  assign w_t   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])} ^ i_rcon;
  assign w_n0  = i_w[127:96] ^ w_t;
  assign w_n1  = i_w[95:64]  ^ w_n0;
  assign w_n2  = i_w[63:32]  ^ w_n1;
  assign w_n3  = i_w[31:0]   ^ w_n2;
  assign o_w   = {w_n0, w_n1, w_n2, w_n3};

endmodule

module aes128_key_sched_ctrl #(
  parameter int NR    = 10,
  parameter int RK_AW = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [127:0]     i_key_in,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic             i_zeroize,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_keys_valid,
  input  logic [RK_AW-1:0] i_rk_addr,
  output logic [127:0]     o_rk_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       r_state;
  logic [3:0]   r_round;
  logic [7:0]   r_rc_byte;
  logic [127:0] r_w;
  logic [127:0] r_rk [0:NR];
  logic         r_busy;
  logic         r_done;
  logic         r_keys_valid;
  logic [127:0] w_next;
  logic         w_clr;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign w_clr = i_reset | i_zeroize;
`else
  assign w_clr = i_reset;
`endif

  aes128_key_exp_round u_round (
    .i_w    (r_w),
    .i_rcon ({r_rc_byte, 24'h000000}),
    .o_w    (w_next)
  );

  // Sequencer FSM: load, ten expansion rounds, one-cycle completion
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state      <= S_IDLE;
      r_round      <= 4'd0;
      r_rc_byte    <= 8'h01;
      r_w          <= 128'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) r_rk[i] <= 128'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_w          <= i_key_in;
            r_rk[0]      <= i_key_in;
            r_round      <= 4'd1;
            r_rc_byte    <= 8'h01;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_EXPAND;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXPAND: begin
          r_rk[r_round] <= w_next;
          r_w           <= w_next;
          r_rc_byte     <= xtime(r_rc_byte);
          // Completion flags are registered here so they are visible during DONE
          if (r_round == 4'(NR)) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
`ifdef KEY_SCHED_ZEROIZE_EN
          r_w     <= 128'h0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Round-key read port; out-of-range or invalid schedule reads as zero
  always_comb begin
    o_rk_data = 128'h0;
    if (r_keys_valid && (i_rk_addr <= RK_AW'(NR))) o_rk_data = r_rk[i_rk_addr];
    else                                          o_rk_data = 128'h0;
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_keys_valid = r_keys_valid;

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Self-checking bench for aes128_key_sched_ctrl: done-timing scoreboard plus known-answer key reads.
module tb_aes128_key_sched_ctrl;

  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2_FIPS  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_ZERO  = 128'h0;
  localparam logic [127:0] RK1_ZERO  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] RK2_ZERO  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rk_addr;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [127:0] rk_data;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_seen = 0;
  int exp_q[$];
  logic [7:0] rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes128_key_sched_ctrl dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_key_in     (key_in),
`ifdef KEY_SCHED_ZEROIZE_EN
    .i_zeroize    (zeroize),
`endif
    .o_busy       (busy),
    .o_done       (done),
    .o_keys_valid (keys_valid),
    .i_rk_addr    (rk_addr),
    .o_rk_data    (rk_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the next expected cycle
  always @(negedge clk) begin
    if (done) begin
      done_seen <= done_seen + 1;
      if (exp_q.size() == 0) chk("done_unexpected", 128'(cyc), 128'(0));
      else                   chk("done_cycle", 128'(cyc), 128'(exp_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input string tag, input logic [127:0] e);
    rk_addr = a;
    #1;
    chk(tag, rk_data, e);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick;
      n++;
    end
    chk("done_wait", 128'(done), 128'(1));
  endtask

  task automatic launch(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    exp_q.push_back(cyc + 11);
    tick;
    start  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; key_in = KEY_ZERO; rk_addr = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    tick; tick;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_kv", 128'(keys_valid), 128'(0));
    chk("rst_rkdata", rk_data, 128'h0);
    reset = 1'b0;
    tick;

    // FIPS-197 key, rcon sequence, key_in changes while busy are ignored
    launch(KEY_FIPS);
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_kv_low", 128'(keys_valid), 128'(0));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rcon_%0d", i), 128'(dut.r_rc_byte), 128'(rcon_exp[i]));
      chk($sformatf("t1_nodone_%0d", i), 128'(done), 128'(0));
      if (i == 3) key_in = KEY_ZERO;
      tick;
    end
    chk("t1_done", 128'(done), 128'(1));
    chk("t1_busy_done", 128'(busy), 128'(0));
    chk("t1_kv_done", 128'(keys_valid), 128'(1));
    tick;
    chk("t1_done_pulse", 128'(done), 128'(0));
    chk("t1_kv_idle", 128'(keys_valid), 128'(1));
    rd(4'd0, "t1_rk0", KEY_FIPS);
    rd(4'd1, "t1_rk1", RK1_FIPS);
    rd(4'd2, "t1_rk2", RK2_FIPS);
    rd(4'd10, "t1_rk10", RK10_FIPS);
    rd(4'd11, "t1_rk11", 128'h0);
    rd(4'd15, "t1_rk15", 128'h0);

    // start held for 15 cycles: second acceptance only after DONE->IDLE
    tick;
    base = done_seen;
    key_in = KEY_FIPS;
    start = 1'b1;
    exp_q.push_back(cyc + 11);
    exp_q.push_back(cyc + 23);
    repeat (15) tick;
    start = 1'b0;
    repeat (20) tick;
    chk("hold_pulses", 128'(done_seen - base), 128'(2));
    chk("hold_q_empty", 128'(exp_q.size()), 128'(0));
    rd(4'd10, "hold_rk10", RK10_FIPS);

    // reset in round 5 wipes everything; reset beats a coincident start
    launch(KEY_FIPS);
    repeat (4) tick;
    chk("mid_round", 128'(dut.r_round), 128'(5));
    reset = 1'b1;
    exp_q.delete();
    tick;
    reset = 1'b0;
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_kv", 128'(keys_valid), 128'(0));
    chk("mid_rk10_store", dut.r_rk[10], 128'h0);
    for (int a = 0; a < 16; a++) rd(4'(a), $sformatf("mid_rd_%0d", a), 128'h0);
    reset = 1'b1; start = 1'b1; key_in = KEY_FIPS;
    tick;
    reset = 1'b0; start = 1'b0;
    tick;
    chk("rst_wins_busy", 128'(busy), 128'(0));
    launch(KEY_FIPS);
    wait_done(15);
    tick;
    rd(4'd10, "fresh_rk10", RK10_FIPS);
    rd(4'd1, "fresh_rk1", RK1_FIPS);
`ifdef KEY_SCHED_ZEROIZE_EN
    chk("w_cleared", dut.r_w, 128'h0);
    zeroize = 1'b1; start = 1'b1;
    tick;
    zeroize = 1'b0; start = 1'b0;
    chk("zz_busy", 128'(busy), 128'(0));
    chk("zz_kv", 128'(keys_valid), 128'(0));
    chk("zz_rk0", dut.r_rk[0], 128'h0);
    chk("zz_rk10", dut.r_rk[10], 128'h0);
    tick;
    chk("zz_no_expand", 128'(busy), 128'(0));
    launch(KEY_FIPS);
    wait_done(15);
    tick;
    chk("zz_w_cleared", dut.r_w, 128'h0);
    rd(4'd10, "zz_rk10_kept", RK10_FIPS);
`else
    chk("w_holds_rk10", dut.r_w, RK10_FIPS);
`endif

    // all-zero key after a valid schedule
    chk("t4_kv_before", 128'(keys_valid), 128'(1));
    launch(KEY_ZERO);
    chk("t4_kv_drop", 128'(keys_valid), 128'(0));
    wait_done(15);
    tick;
    rd(4'd1, "t4_rk1", RK1_ZERO);
    rd(4'd2, "t4_rk2", RK2_ZERO);
    rd(4'd10, "t4_rk10", RK10_ZERO);
    rd(4'd12, "t4_rk12", 128'h0);
    repeat (3) tick;
    chk("final_q_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
